// File: rtl/data_mem_arbiter.sv
`default_nettype none
// data_mem_arbiter: two-port arbiter with ownership locking onto a single-port data memory.
// Rev 1.0 -- optional round-robin contention policy via DMEM_ARB_ROUND_ROBIN_EN.
module data_mem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int LOCK_MAX = 15
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              req0,
   input  logic              req1,
   input  logic              wen0,
   input  logic              wen1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              memWen,
   output logic [ADDR_W-1:0] memAddress,
   output logic [DATA_W-1:0] memWriteData,
   input  logic [DATA_W-1:0] memDataOut,
   output logic              lockErr
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] LOCK0    = 2'd1;
   localparam logic [1:0] LOCK1    = 2'd2;
   localparam logic [3:0] CNT_LAST = 4'(LOCK_MAX - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] idle_cnt;
   logic [3:0] idle_cnt_nxt;
   logic       err_nxt;
   logic       last_grant;
   logic       pick1;
   logic       own_req;
   logic       own_lock;
   logic       own_gnt;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   assign pick1 = ~last_grant;
`else
   // Fixed priority: port 0 always wins; last_grant is still tracked.
   assign pick1 = last_grant & 1'b0;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (resetN) begin
         case (state)
            IDLE: begin
               if (req0 && req1) begin
                  gnt1 = pick1;
                  gnt0 = ~pick1;
               end else begin
                  gnt0 = req0;
                  gnt1 = req1;
               end
            end
            LOCK0:   gnt0 = req0;
            LOCK1:   gnt1 = req1;
            default: ;
         endcase
      end
   end

   assign memWen       = (gnt0 & wen0) | (gnt1 & wen1);
   assign memAddress   = gnt1 ? addr1  : addr0;
   assign memWriteData = gnt1 ? wdata1 : wdata0;

   // Signals of whichever port currently owns the memory (meaningful only in LOCKn).
   assign own_req  = (state == LOCK1) ? req1  : req0;
   assign own_lock = (state == LOCK1) ? lock1 : lock0;
   assign own_gnt  = (state == LOCK1) ? gnt1  : gnt0;

   always_comb begin
      state_nxt    = state;
      idle_cnt_nxt = idle_cnt;
      err_nxt      = 1'b0;
      case (state)
         IDLE: begin
            idle_cnt_nxt = 4'd0;
            if (gnt0 && lock0)      state_nxt = LOCK0;
            else if (gnt1 && lock1) state_nxt = LOCK1;
         end
         LOCK0, LOCK1: begin
            if (own_gnt) begin
               idle_cnt_nxt = 4'd0;
               if (!own_lock) state_nxt = IDLE;
            end else if (!own_req && !own_lock) begin
               idle_cnt_nxt = 4'd0;
               state_nxt    = IDLE;
            end else if (idle_cnt == CNT_LAST) begin
               idle_cnt_nxt = 4'd0;
               state_nxt    = IDLE;
               err_nxt      = 1'b1;
            end else begin
               idle_cnt_nxt = idle_cnt + 4'd1;
            end
         end
         default: begin
            idle_cnt_nxt = 4'd0;
            state_nxt    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         idle_cnt   <= 4'd0;
         lockErr    <= 1'b0;
         last_grant <= 1'b1;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         state    <= state_nxt;
         idle_cnt <= idle_cnt_nxt;
         lockErr  <= err_nxt;
         if (gnt1)      last_grant <= 1'b1;
         else if (gnt0) last_grant <= 1'b0;
         rvalid0 <= gnt0 & ~wen0;
         rvalid1 <= gnt1 & ~wen1;
         if (gnt0 && !wen0) rdata0 <= memDataOut;
         if (gnt1 && !wen1) rdata1 <= memDataOut;
      end
   end

endmodule
`default_nettype wire
